// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the round-robin bit-serial adder scheduler.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;
    localparam int MAX_NREQ  = 32;

    // First set bit of valid at or above ptr, wrapping modulo nreq; returns ptr when none is set.
    function automatic logic [4:0] rr_grant(input logic [MAX_NREQ-1:0] valid,
                                            input logic [4:0]          ptr,
                                            input int                  nreq);
        logic [4:0] grant;
        logic       found;
        int         idx;
        grant = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = (int'(ptr) + k) % nreq;
            if (k < nreq && !found && valid[idx]) begin
                grant = 5'(idx);
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Request and response handshake bundle between operand sources and the scheduler.
interface serial_add_sched_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: operand shift registers, one full adder, carry flop, sum shift register.
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             s_bit;
    logic             carry_next;

    assign s_bit      = sa_reg[0] ^ sb_reg[0] ^ carry_reg;
    assign carry_next = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & carry_reg) | (sb_reg[0] & carry_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            sa_reg    <= '0;
            sb_reg    <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            if (clear) begin
                sum_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (shift_en) begin
                sum_reg   <= {s_bit, sum_reg[WIDTH-1:1]};
                carry_reg <= carry_next;
            end
            if (load) begin
                sa_reg <= a;
                sb_reg <= b;
            end else if (shift_en) begin
                sa_reg <= sa_reg >> 1;
                sb_reg <= sb_reg >> 1;
            end
        end
    end

    // After the last shift the carry flop holds the carry out of the MSB.
    assign sum  = sum_reg;
    assign cout = carry_reg;
endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler that time-shares one bit-serial adder among NREQ requesters.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic               clk,
    input  logic               reset,
    serial_add_sched_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    count_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   grant;
    logic             accept;
    logic             shift_en;
    logic             rsp_valid_c;
    logic [NREQ-1:0]  req_ready_vec;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign grant = IDW'(rr_grant(MAX_NREQ'(bus.req_valid), 5'(rr_ptr_reg), NREQ));
    assign a_sel = bus.req_a[grant*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[grant*WIDTH +: WIDTH];

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        shift_en    = 1'b0;
        rsp_valid_c = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            rr_ptr_reg <= '0;
            id_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                count_reg  <= '0;
                id_reg     <= grant;
                rr_ptr_reg <= IDW'((int'(grant) + 1) % NREQ);
            end else if (shift_en) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    // Ready is a one-hot decode of the grant, only while an accept is happening.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready_vec[gi] = accept && (grant == IDW'(gi));
        end
    endgenerate

    serial_add_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift_en (shift_en),
        .clear    (accept),
        .a        (a_sel),
        .b        (b_sel),
        .sum      (sum),
        .cout     (cout)
    );

    assign bus.req_ready = req_ready_vec;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_sum   = sum;
    assign bus.rsp_cout  = cout;
    assign bus.rsp_id    = id_reg;
endmodule

// File: tb/tb_serial_add_sched.sv
// Directed checks of serial_add_sched: arithmetic, latency, round-robin, backpressure, reset abort.
module tb_serial_add_sched;
    localparam int WIDTH = 8;
    localparam int NREQ  = 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    serial_add_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    serial_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, got);
        end
    endtask

    task automatic set_req(input int who, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[who*WIDTH +: WIDTH] = a;
        bus.req_b[who*WIDTH +: WIDTH] = b;
    endtask

    // Single-requester transaction with rsp_ready held high.
    task automatic run_op(input string tag, input int who, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input logic exp_cout);
        int waitc;
        int lat;
        set_req(who, a, b);
        bus.req_valid      = '0;
        bus.req_valid[who] = 1'b1;
        bus.rsp_ready      = 1'b1;
        #1;
        waitc = 0;
        while (!bus.req_ready[who] && waitc < 20) begin
            tick();
            waitc++;
        end
        check_eq({tag, "_wait"}, waitc, 0);
        tick();
        bus.req_valid = '0;
        bus.req_a     = '1;
        bus.req_b     = '1;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, WIDTH);
        check_eq({tag, "_sum"}, bus.rsp_sum, exp_sum);
        check_eq({tag, "_cout"}, bus.rsp_cout, exp_cout);
        check_eq({tag, "_id"}, bus.rsp_id, who);
        tick();
        check_eq({tag, "_done"}, bus.rsp_valid, 0);
    endtask

    initial begin
        int acc;
        int rsp_n;
        int cyc;
        int last;
        int cnt;
        logic [7:0] alt_sum [2];

        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_valid", bus.rsp_valid, 0);
        check_eq("rst_sum", bus.rsp_sum, 0);
        check_eq("rst_cout", bus.rsp_cout, 0);
        check_eq("rst_id", bus.rsp_id, 0);

        // rr_ptr is 0 here, so requester 1 alone must be granted at once.
        run_op("r1_ff01", 1, 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("r0_1b15", 0, 8'h1B, 8'h15, 8'h30, 1'b0);
        run_op("r1_ffff", 1, 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // Both requesters held valid: grants alternate 0,1,0,1 at 10-cycle spacing.
        alt_sum[0] = 8'h30;
        alt_sum[1] = 8'h00;
        set_req(0, 8'h10, 8'h20);
        set_req(1, 8'h80, 8'h80);
        bus.req_valid = 2'b11;
        #1;
        acc = 0;
        rsp_n = 0;
        cyc = 0;
        last = 0;
        while ((acc < 4 || rsp_n < 4) && cyc < 80) begin
            if (|bus.req_ready) begin
                check_eq("alt_grant", bus.req_ready, (acc % 2 == 0) ? 2'b01 : 2'b10);
                if (acc > 0) check_eq("alt_gap", cyc - last, 10);
                last = cyc;
                acc++;
            end
            if (bus.rsp_valid) begin
                check_eq("alt_rsp_id", bus.rsp_id, rsp_n % 2);
                check_eq("alt_rsp_sum", {bus.rsp_cout, bus.rsp_sum}, {(rsp_n % 2 == 1), alt_sum[rsp_n % 2]});
                rsp_n++;
            end
            tick();
            cyc++;
            if (acc == 4) bus.req_valid = '0;
        end
        check_eq("alt_accepts", acc, 4);
        check_eq("alt_rsps", rsp_n, 4);

        // Backpressure in DONE for 5 cycles with another requester waiting.
        set_req(0, 8'h3C, 8'h0F);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #1;
        cnt = 0;
        while (!bus.req_ready[0] && cnt < 20) begin
            tick();
            cnt++;
        end
        check_eq("bp_wait", cnt, 0);
        tick();
        bus.req_valid = '0;
        cnt = 0;
        while (!bus.rsp_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq("bp_lat", cnt, WIDTH);
        set_req(1, 8'h01, 8'h02);
        bus.req_valid = 2'b10;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold", {bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum, bus.req_ready},
                     {1'b1, 1'b0, 1'b0, 8'h4B, 2'b00});
            tick();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        #1;
        check_eq("bp_hs_valid", bus.rsp_valid, 1);
        tick();
        check_eq("bp_after", bus.rsp_valid, 0);

        // Reset in mid-SHIFT (count=3) discards the operation.
        set_req(1, 8'hFF, 8'hFF);
        bus.req_valid = 2'b10;
        #1;
        cnt = 0;
        while (!bus.req_ready[1] && cnt < 20) begin
            tick();
            cnt++;
        end
        check_eq("rs_wait", cnt, 0);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        check_eq("rs_pre_cout", bus.rsp_cout, 1);
        check_eq("rs_pre_id", bus.rsp_id, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rs_outs", {bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum, bus.req_ready}, 0);
        cnt = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            if (bus.rsp_valid) cnt++;
            tick();
        end
        check_eq("rs_no_rsp", cnt, 0);
        run_op("post_rst", 0, 8'h7F, 8'h01, 8'h80, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Round-robin scheduler and sequencer that shares one bit-serial adder datapath between NREQ requesters. It accepts an operand pair from one requester via a valid/ready handshake, then clocks the pair LSB-first through a single full adder for WIDTH cycles. It returns the WIDTH-bit sum, carry-out and requester ID on a response handshake. It sits between the operand sources and the serial-add datapath, replacing the free-running load/reset sequencing with explicit control.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- NREQ, 2, number of requesters (≥2); IDW = $clog2(NREQ) derived locally
- clk  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept, at most one bit set
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  (A+B) mod 2^WIDTH
- rsp_cout  out  1  carry out of bit WIDTH-1
- rsp_id  out  IDW  index of the requester that issued the operation

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE, rr_ptr=0, count=0, carry=0, shift registers=0.
- IDLE:
  - Grant goes to the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[grant] is asserted combinationally in the same cycle. All req_ready are 0 outside IDLE or when no valid is high.
  - On accept: latch req_a/req_b of grant into sa/sb, carry←0, count←0, id←grant, rr_ptr←(grant+1) mod NREQ, go to SHIFT.
- SHIFT, once per cycle:
  - s = sa[0]^sb[0]^carry; carry←majority(sa[0],sb[0],carry).
  - sum←{s, sum[WIDTH-1:1]}; sa, sb shift right with 0 fill; count++.
  - When count==WIDTH-1 in SHIFT, the next state is DONE, so there are exactly WIDTH SHIFT cycles.
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id come from registers and stay stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready → IDLE.
- Arithmetic: unsigned; the sum wraps mod 2^WIDTH and overflow appears only on rsp_cout.
- Requester payload may change after its accept cycle without effect.
- Requesters not granted keep req_valid asserted; the scheduler never drops or reorders a pending request beyond the round-robin rule.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
- Accept at cycle T → SHIFT in cycles T+1..T+WIDTH → rsp_valid first high at T+WIDTH+1.
- Response handshake at cycle R → IDLE at R+1, so the earliest next accept is at R+1.
- Minimum period is WIDTH+2 cycles per operation with rsp_ready held high.
- Simultaneous valids: the grant follows rr_ptr. With NREQ=2 and both held high, grants alternate 0,1,0,1….
- A requester whose valid drops before a grant is simply skipped; rr_ptr is unchanged if no grant occurs.
- Reset asserted in any state (mid-SHIFT, or DONE with rsp_ready low): the next edge returns all state to reset values. The in-flight operation is discarded and no rsp_valid is produced for it.
- Backpressure in DONE is unbounded and outputs hold exactly.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the default WIDTH and NREQ constants;
  - a function computing the round-robin grant index from a valid vector and a pointer.
- Sub-module serial_add_core holds the datapath: sa/sb/sum shift registers, carry flop and full adder, with load, shift_en and clear inputs.
- The top level holds the FSM, the bit counter, the arbiter and the handshakes.

## Test plan
- WIDTH=8, requester 0 sends a=27 (0x1B), b=21 (0x15), accepted at T → rsp_valid at T+9 with sum=48 (0x30), cout=0, id=0.
- a=0xFF, b=0x01 from requester 1 → sum=0x00, cout=1, id=1. Then a=0xFF, b=0xFF → sum=0xFE, cout=1.
- Both req_valid held high with distinct operands, rsp_ready=1 → grants 0,1,0,1. Each req_ready is a one-cycle pulse, and accepts are 10 cycles apart.
- rsp_ready held 0 for 5 cycles in DONE → rsp_valid, sum, cout and id stay constant, req_ready stays 0. The handshake completes on the cycle rsp_ready rises.
- Reset pulsed at SHIFT count=3 → next cycle all outputs are 0 and the state is IDLE. A fresh request is accepted and produces the correct result with carry cleared.
- Only requester 1 valid, with rr_ptr=0 → it is granted immediately and rr_ptr becomes 0 again.
